em_ctrl: RTL

- Parametrised successor to the team's byte-addressed external memory.
- Byte RAM with a handshaked data port: byte, halfword or word, little-endian, with configurable wait states.
- Separate combinational instruction-fetch port returning a 16-bit halfword, with forwarding of an in-flight write.
- Post-reset clear sequencer; out-of-range and illegal-size accesses reported as faults instead of silently dropped.

---
 rtl/em_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/em_ctrl.sv
// em_ctrl: byte RAM with a handshaked data port and a combinational 16-bit fetch port.
// The data port supports byte, half and word accesses, little-endian, with wait states.
// Out-of-range and reserved-size accesses complete with fault instead of being dropped.
// A clear sequencer zeroes the RAM after reset.
// Optional macro EM_CTRL_PRELOAD_EN: reset skips the clear so RAM contents survive reset.
module em_ctrl #(
    parameter int unsigned MEM_BYTES   = 96,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] NOP_INSTR   = 16'hE800
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic              busy,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [15:0]       fetch_data,
    output logic              fetch_valid
);

    localparam int unsigned   IDX_W = $clog2(MEM_BYTES);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(MEM_BYTES - 1);

    typedef enum logic [2:0] {StClear, StIdle, StWait, StAccess, StResp} state_t;

    logic [7:0]        mem [MEM_BYTES];
    state_t            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [ADDR_W:0]   ba [4];
    logic [3:0]        used;
    logic              acc_fault;
    logic [31:0]       rd_word;
    logic [ADDR_W:0]   fa_lo;
    logic [ADDR_W:0]   fa_hi;
    logic [7:0]        f_lo;
    logic [7:0]        f_hi;

`ifdef EM_CTRL_PRELOAD_EN
    localparam state_t ResetState = StIdle;
    localparam logic   ClearGate  = 1'b0;
`else
    localparam state_t ResetState = StClear;
    localparam logic   ClearGate  = 1'b1;
`endif

    assign busy = (state_q != StIdle);

    // Decode the latched access: byte addresses (no wrap), active lanes, fault and read word.
    always_comb begin
        acc_fault = (size_q == 2'd3);
        rd_word   = 32'h0;
        used      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ba[i]   = {1'b0, addr_q} + (ADDR_W+1)'(i);
            used[i] = (i == 0) || ((i == 1) && (size_q != 2'd0)) || ((i >= 2) && (size_q == 2'd2));
            if (used[i] && (ba[i] >= LIMIT)) begin
                acc_fault = 1'b1;
            end
            if (used[i]) begin
                rd_word[8*i +: 8] = mem[ba[i][IDX_W-1:0]];
            end
        end
    end

    // Fetch port: two RAM bytes, with the in-flight write forwarded during ACCESS.
    always_comb begin
        fa_lo       = {1'b0, fetch_addr};
        fa_hi       = fa_lo + 1'b1;
        fetch_valid = !(ClearGate && (state_q == StClear)) && (fa_hi < LIMIT);
        f_lo        = mem[fa_lo[IDX_W-1:0]];
        f_hi        = mem[fa_hi[IDX_W-1:0]];
        if ((state_q == StAccess) && we_q && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (used[i] && (ba[i] == fa_lo)) f_lo = wdata_q[8*i +: 8];
                if (used[i] && (ba[i] == fa_hi)) f_hi = wdata_q[8*i +: 8];
            end
        end
        fetch_data = fetch_valid ? {f_hi, f_lo} : NOP_INSTR;
    end

    // Controller FSM with registered ack/fault/rdata; also owns all RAM writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ResetState;
            ptr_q   <= '0;
            cnt_q   <= 4'd0;
            ack     <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            ack   <= 1'b0;
            fault <= 1'b0;
            unique case (state_q)
                StClear: begin
                    mem[ptr_q] <= 8'h00;
                    ptr_q      <= ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) state_q <= StIdle;
                end
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_CYCLES > 0) begin
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                            state_q <= StWait;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) state_q <= StAccess;
                    else cnt_q <= cnt_q - 4'd1;
                end
                StAccess: begin
                    if (acc_fault) begin
                        rdata <= 32'h0;
                        fault <= 1'b1;
                    end else if (we_q) begin
                        for (int i = 0; i < 4; i++) begin
                            if (used[i]) mem[ba[i][IDX_W-1:0]] <= wdata_q[8*i +: 8];
                        end
                    end else begin
                        rdata <= rd_word;
                    end
                    ack     <= 1'b1;
                    state_q <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
